// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Brief   : 5-stage pipeline hazard controller (load-use stall, branch flush,
//           saturating stall/flush performance counters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int FLUSH_LEN = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             ext_hold_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int FCW = (FLUSH_LEN > 2) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FCW-1:0] C_FCNT_INIT = FCW'((FLUSH_LEN > 1) ? FLUSH_LEN - 2 : 0);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  logic [FCW-1:0]   r_fcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_load_use;

  assign w_load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                      ((idex_rt_i == ifid_rs_i) ||
                       (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

  // Outputs are combinational so a hazard takes effect in the cycle it is seen.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    if (!rst_n) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else if (ext_hold_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_load_use) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
          end
        end
        FLUSH: begin
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_fcnt      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!ext_hold_i) begin
      if (branch_taken_i) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
        r_fcnt  <= C_FCNT_INIT;
        r_state <= (FLUSH_LEN > 1) ? FLUSH : RUN;
      end else begin
        case (r_state)
          RUN: begin
            if (w_load_use) begin
              if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
              r_state <= STALL;
            end
          end
          STALL: r_state <= RUN;
          FLUSH: begin
            if (r_fcnt == '0) r_state <= RUN;
            else              r_fcnt  <= r_fcnt - 1'b1;
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Directed self-checking bench for hazard_ctrl (FLUSH_LEN=2, CNT_W=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       ext_hold_i = 1'b0;
  logic       idex_memread_i = 1'b0;
  logic [4:0] idex_rt_i = 5'd0;
  logic [4:0] ifid_rs_i = 5'd0;
  logic [4:0] ifid_rt_i = 5'd0;
  logic       ifid_uses_rt_i = 1'b0;
  logic       branch_taken_i = 1'b0;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o;
  logic [3:0] stall_cnt_o, flush_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.FLUSH_LEN(2), .CNT_W(4)) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .ext_hold_i     (ext_hold_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .ifid_uses_rt_i (ifid_uses_rt_i),
    .branch_taken_i (branch_taken_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_flush_o   (idex_flush_o),
    .exmem_flush_o  (exmem_flush_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}
  wire [4:0] w_ctl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o};
  // Same without ifid_write, whose value is irrelevant while IF/ID is flushed.
  wire [3:0] w_fl  = {pc_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_use_on(input logic [4:0] rt, input logic [4:0] rs);
    idex_memread_i = 1'b1;
    idex_rt_i      = rt;
    ifid_rs_i      = rs;
  endtask

  initial begin
    // Reset held for 3 clocks
    tick(); tick(); tick();
    chk("rst_ctl",   {3'b0, w_ctl}, 8'h07);
    chk("rst_stall", {4'b0, stall_cnt_o}, 8'h0);
    chk("rst_flush", {4'b0, flush_cnt_o}, 8'h0);
    tick(); rst_n = 1'b1; #1;
    chk("run_ctl", {3'b0, w_ctl}, 8'h18);

    // Load-use on rs
    tick(); load_use_on(5'd5, 5'd5); #1;
    chk("lu_rs_stall", {3'b0, w_ctl}, 8'h02);
    tick();
    chk("lu_rs_masked", {3'b0, w_ctl}, 8'h18);
    chk("lu_rs_cnt", {4'b0, stall_cnt_o}, 8'h1);
    tick(); load_use_on(5'd0, 5'd0); #1;
    chk("lu_r0_none", {3'b0, w_ctl}, 8'h18);
    tick();
    chk("lu_r0_cnt", {4'b0, stall_cnt_o}, 8'h1);

    // rt match only counts when the ID instruction reads rt
    load_use_on(5'd7, 5'd0); ifid_rt_i = 5'd7; ifid_uses_rt_i = 1'b0; #1;
    chk("lu_rt_gated", {3'b0, w_ctl}, 8'h18);
    tick(); ifid_uses_rt_i = 1'b1; #1;
    chk("lu_rt_stall", {3'b0, w_ctl}, 8'h02);
    tick();
    chk("lu_rt_masked", {3'b0, w_ctl}, 8'h18);
    chk("lu_rt_cnt", {4'b0, stall_cnt_o}, 8'h2);

    // Branch coincident with load-use: branch wins
    tick(); branch_taken_i = 1'b1; #1;
    chk("br_c0", {4'b0, w_fl}, 8'hF);
    tick(); branch_taken_i = 1'b0; #1;
    chk("br_c1", {4'b0, w_fl}, 8'hE);
    chk("br_flush_cnt", {4'b0, flush_cnt_o}, 8'h1);
    chk("br_stall_cnt", {4'b0, stall_cnt_o}, 8'h2);
    tick(); idex_memread_i = 1'b0; #1;
    chk("br_c2", {3'b0, w_ctl}, 8'h18);

    // ext_hold freezes FLUSH; remaining flush cycle completes on release
    tick(); branch_taken_i = 1'b1; #1;
    chk("hb_c0", {4'b0, w_fl}, 8'hF);
    tick(); branch_taken_i = 1'b0; ext_hold_i = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_ctl", {3'b0, w_ctl}, 8'h00);
      tick();
    end
    ext_hold_i = 1'b0; #1;
    chk("hold_rel_flush", {4'b0, w_fl}, 8'hE);
    tick();
    chk("hold_rel_run", {3'b0, w_ctl}, 8'h18);
    chk("hold_flush_cnt", {4'b0, flush_cnt_o}, 8'h2);

    // Saturation: 20 more load-use events on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      load_use_on(5'd5, 5'd5);
      tick();
      idex_memread_i = 1'b0;
      tick();
    end
    chk("sat_stall_cnt", {4'b0, stall_cnt_o}, 8'hF);

    // Asynchronous reset in the middle of FLUSH
    branch_taken_i = 1'b1; tick(); branch_taken_i = 1'b0; #1;
    chk("mf_flush", {4'b0, w_fl}, 8'hE);
    rst_n = 1'b0; #1;
    chk("mf_rst_ctl",   {3'b0, w_ctl}, 8'h07);
    chk("mf_rst_stall", {4'b0, stall_cnt_o}, 8'h0);
    chk("mf_rst_flush", {4'b0, flush_cnt_o}, 8'h0);
    tick(); rst_n = 1'b1; #1;
    chk("mf_run", {3'b0, w_ctl}, 8'h18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
